// File: rtl/v2f_divmod_arbiter.sv
// v2f_divmod_arbiter: round-robin shared div/mod pipeline; define V2F_DIVMOD_DZ_TRAP_EN for a sticky divide-by-zero flag
module v2f_divmod_arbiter #(
  parameter int NREQ = 4,
  parameter int WIDTH = 32,
  parameter int LAT = 2,
  parameter int SIGNED = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_mod,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [WIDTH-1:0]        rsp_data,
  output logic                    rsp_dz,
  output logic [2:0]              inflight,
  output logic                    dz_err
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  logic [IW-1:0] ptr, win;
  logic found, xfer;
  logic [LAT-1:0] sv, sm;
  logic [IW-1:0] sid [LAT];
  logic [WIDTH-1:0] sa [LAT];
  logic [WIDTH-1:0] sb [LAT];
  logic [WIDTH-1:0] fa, fb, bd, res;
  logic signed [WIDTH-1:0] sq, sr;
  logic fm, ovf;
  // scan from ptr upward; the lowest offset wins because it is assigned last
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(ptr) + k) % NREQ]) begin
        win = IW'((int'(ptr) + k) % NREQ);
        found = 1'b1;
      end
    end
  end
  assign req_ready = (found && !rst) ? (NREQ'(1) << win) : '0;
  assign xfer = found && !rst;
  assign fa = sa[LAT-1];
  assign fb = sb[LAT-1];
  assign fm = sm[LAT-1];
  assign ovf = (SIGNED != 0) && fa == MIN && fb == '1;
  // divisor is forced to 1 in the zero and overflow cases so the divider never sees them
  assign bd = (fb == '0 || ovf) ? WIDTH'(1) : fb;
  assign sq = $signed(fa) / $signed(bd);
  assign sr = $signed(fa) % $signed(bd);
  assign res = fb == '0 ? '0 :
               ovf ? (fm ? '0 : MIN) :
               fm ? ((SIGNED != 0) ? sr : fa % bd) :
               ((SIGNED != 0) ? sq : fa / bd);
  // stage valids: cleared by reset so in-flight work is dropped
  always_ff @(posedge clk) begin
    if (rst) sv <= '0;
    else begin
      sv[0] <= xfer;
      for (int i = 1; i < LAT; i++) sv[i] <= sv[i-1];
    end
  end
  // stage payload: capture winner operands, then shift toward the divider
  always_ff @(posedge clk) begin
    sid[0] <= win;
    sm[0] <= req_mod[win];
    sa[0] <= req_a[int'(win)*WIDTH +: WIDTH];
    sb[0] <= req_b[int'(win)*WIDTH +: WIDTH];
    for (int i = 1; i < LAT; i++) begin
      sid[i] <= sid[i-1];
      sm[i] <= sm[i-1];
      sa[i] <= sa[i-1];
      sb[i] <= sb[i-1];
    end
  end
  // response registers, occupancy counter and priority pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_data <= '0;
      rsp_dz <= 1'b0;
      inflight <= '0;
      ptr <= '0;
    end else begin
      rsp_valid <= sv[LAT-1] ? (NREQ'(1) << sid[LAT-1]) : '0;
      rsp_data <= sv[LAT-1] ? res : '0;
      rsp_dz <= sv[LAT-1] && fb == '0;
      inflight <= inflight + 3'(xfer) - 3'(sv[LAT-1]);
      if (xfer) ptr <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
    end
  end
`ifdef V2F_DIVMOD_DZ_TRAP_EN
  // sticky flag set by any divide-by-zero response until reset
  always_ff @(posedge clk) begin
    if (rst) dz_err <= 1'b0;
    else if (sv[LAT-1] && fb == '0) dz_err <= 1'b1;
  end
`else
  assign dz_err = 1'b0;
`endif
endmodule

// File: tb/tb_v2f_divmod_arbiter.sv
// tb_v2f_divmod_arbiter: directed table, corner sequences and random traffic against a queue model
module tb_v2f_divmod_arbiter;
  localparam int N = 4, W = 32, L = 2;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [N-1:0] req_valid, req_mod, req_ready, rsp_valid, req_ready_s, rsp_valid_s;
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0] rsp_data, rsp_data_s;
  logic rsp_dz, rsp_dz_s, dz_err, dz_err_s;
  logic [2:0] inflight, inflight_s;

  v2f_divmod_arbiter #(.NREQ(N), .WIDTH(W), .LAT(L), .SIGNED(0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_mod(req_mod), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_dz(rsp_dz),
    .inflight(inflight), .dz_err(dz_err));
  v2f_divmod_arbiter #(.NREQ(N), .WIDTH(W), .LAT(L), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_mod(req_mod), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready_s), .rsp_valid(rsp_valid_s), .rsp_data(rsp_data_s), .rsp_dz(rsp_dz_s),
    .inflight(inflight_s), .dz_err(dz_err_s));

  int total = 0, bad = 0;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {int id; logic m; logic [W-1:0] a, b; int t;} op_t;
  op_t q[$];
  int mptr = 0, ecount = 0;
  logic sticky = 0;
  logic [N-1:0] obs_ready, obs_rv;
  logic [W-1:0] obs_d, obs_ds;
  logic obs_dz;

  function automatic logic [W-1:0] ref_res(logic [W-1:0] a, logic [W-1:0] b, logic m, bit sg);
    longint sa, sb;
    if (b == 0) return '0;
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return W'(m ? sa % sb : sa / sb);
    end
    return m ? a % b : a / b;
  endfunction

  task automatic set_req(int id, logic m, logic [W-1:0] a, logic [W-1:0] b);
    req_valid[id] = 1'b1;
    req_mod[id] = m;
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
  endtask

  task automatic tick();
    logic [N-1:0] er, ev;
    logic [W-1:0] ed, eds;
    logic edz;
    int w;
    op_t o;
    #1;
    er = '0; w = -1;
    if (!rst) for (int k = 0; k < N; k++) if (w < 0 && req_valid[(mptr + k) % N]) w = (mptr + k) % N;
    if (w >= 0) er[w] = 1'b1;
    obs_ready = req_ready;
    chk("ready", req_ready, er);
    chk("ready_s", req_ready_s, er);
    if (w >= 0) begin
      q.push_back('{w, req_mod[w], req_a[w*W +: W], req_b[w*W +: W], ecount + 1});
      mptr = (w + 1) % N;
    end
    @(posedge clk);
    ecount++;
    if (rst) begin q.delete(); mptr = 0; sticky = 0; end
    @(negedge clk);
    ev = '0; ed = '0; eds = '0; edz = 0;
    if (q.size() > 0 && q[0].t + L == ecount) begin
      o = q.pop_front();
      ev[o.id] = 1'b1;
      ed = ref_res(o.a, o.b, o.m, 0);
      eds = ref_res(o.a, o.b, o.m, 1);
      edz = (o.b == 0);
      if (edz) sticky = 1;
    end
    chk("rsp_valid", rsp_valid, ev);
    chk("rsp_valid_s", rsp_valid_s, ev);
    if (ev != 0) begin
      chk("rsp_data", rsp_data, ed);
      chk("rsp_data_s", rsp_data_s, eds);
      chk("rsp_dz", rsp_dz, edz);
      chk("rsp_dz_s", rsp_dz_s, edz);
    end
    chk("inflight", inflight, q.size());
    chk("inflight_s", inflight_s, q.size());
`ifdef V2F_DIVMOD_DZ_TRAP_EN
    chk("dz_err", dz_err, sticky);
`else
    chk("dz_err", dz_err, 0);
`endif
    obs_rv = rsp_valid; obs_d = rsp_data; obs_ds = rsp_data_s; obs_dz = rsp_dz;
  endtask

  typedef struct {int id; logic m; logic [W-1:0] a, b, eu, es; logic dz;} vec_t;
  vec_t tv[9];

  initial begin
    tv[0] = '{1, 0, 100, 7, 14, 14, 0};
    tv[1] = '{1, 1, 100, 7, 2, 2, 0};
    tv[2] = '{2, 0, 32'hFFFFFFF9, 2, 32'h7FFFFFFC, 32'hFFFFFFFD, 0};
    tv[3] = '{2, 1, 32'hFFFFFFF9, 2, 1, 32'hFFFFFFFF, 0};
    tv[4] = '{3, 1, 7, 32'hFFFFFFFE, 7, 1, 0};
    tv[5] = '{0, 0, 32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000, 0};
    tv[6] = '{0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0};
    tv[7] = '{3, 1, 5, 0, 0, 0, 1};
    tv[8] = '{0, 0, 5, 0, 0, 0, 1};
    req_valid = '0; req_mod = '0; req_a = '0; req_b = '0;
    rst = 1;
    tick(); tick();
    chk("reset_rv", rsp_valid, 0);
    chk("reset_data", rsp_data, 0);
    chk("reset_dz", rsp_dz, 0);
    chk("reset_inflight", inflight, 0);
    chk("reset_dz_err", dz_err, 0);
    rst = 0;
    for (int i = 0; i < 9; i++) begin
      req_valid = '0;
      set_req(tv[i].id, tv[i].m, tv[i].a, tv[i].b);
      tick();
      chk("tv_ready", obs_ready, N'(1) << tv[i].id);
      req_valid = '0;
      repeat (L) tick();
      chk("tv_rsp_valid", obs_rv, N'(1) << tv[i].id);
      chk("tv_data_u", obs_d, tv[i].eu);
      chk("tv_data_s", obs_ds, tv[i].es);
      chk("tv_dz", obs_dz, tv[i].dz);
    end
    tick();
`ifdef V2F_DIVMOD_DZ_TRAP_EN
    chk("dz_sticky", dz_err, 1);
`else
    chk("dz_sticky", dz_err, 0);
`endif
    rst = 1; tick(); rst = 0;
    chk("dz_cleared", dz_err, 0);
    for (int i = 0; i < N; i++) set_req(i, i[0], 100 + 10 * i, 3 + i);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_grant", obs_ready, N'(1) << (i % N));
    end
    chk("rr_saturate", inflight, L);
    req_valid = '0;
    repeat (L + 1) tick();
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < N; i++) set_req(i, 0, 50, 5);
    tick(); tick();
    rst = 1; tick(); rst = 0;
    req_valid = '0;
    repeat (L + 1) begin
      tick();
      chk("mid_rst_rv", obs_rv, 0);
    end
    chk("mid_rst_inflight", inflight, 0);
    req_valid = '1;
    tick();
    chk("mid_rst_ptr", obs_ready, 4'b0001);
    req_valid = '0;
    repeat (L) tick();
    rst = 1; tick(); rst = 0;
    set_req(2, 0, 9, 3);
    tick();
    req_valid = '0;
    set_req(3, 0, 8, 2);
    set_req(0, 1, 8, 3);
    tick();
    chk("wrap_grant3", obs_ready, 4'b1000);
    req_valid[3] = 0;
    tick();
    chk("wrap_grant0", obs_ready, 4'b0001);
    req_valid = '0;
    repeat (L) tick();
    rst = 1; tick(); rst = 0;
    set_req(0, 0, 1, 1);
    set_req(1, 0, 2, 1);
    tick();
    req_valid[0] = 0;
    set_req(2, 0, 3, 1);
    tick();
    chk("drop_grant1", obs_ready, 4'b0010);
    req_valid = '0;
    tick();
    chk("drop_none", obs_ready, 4'b0000);
    req_valid = '1;
    tick();
    chk("drop_ptr_held", obs_ready, 4'b0100);
    req_valid = '0;
    repeat (L) tick();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && !obs_ready[i]) begin
          if ($urandom_range(0, 99) < 10) req_valid[i] = 0;
        end else begin
          logic [W-1:0] a, b;
          req_valid[i] = 0;
          a = ($urandom_range(0, 9) == 0) ? 32'h80000000 :
              ($urandom_range(0, 1) == 0) ? $urandom : W'($urandom_range(0, 200)) - 100;
          b = ($urandom_range(0, 9) == 0) ? 32'h0 :
              ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFF :
              ($urandom_range(0, 1) == 0) ? $urandom : W'($urandom_range(0, 40)) - 20;
          if ($urandom_range(0, 99) < 45) set_req(i, $urandom_range(0, 1) == 1, a, b);
        end
      end
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 0;
    req_valid = '0;
    repeat (L + 1) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/v2f_divmod_arbiter.md
# v2f_divmod_arbiter

Round-robin arbiter and sequencer sharing one pipelined divide/modulo datapath (v2f_div / v2f_mod semantics) among NREQ requesters. It accepts at most one operation per cycle, tags it with the requester index, and returns the result to that requester after a fixed LAT cycles. It sits between several synthesized consumers of `/` and `%` and a single shared combinator chain, saving divider area in generated blueprints.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 32, operand and result width in bits
- LAT, 2, pipeline depth from grant to response (1..4)
- SIGNED, 0, 1 = signed operands, 0 = unsigned

- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request strobe
- req_mod  in  NREQ  per-requester op select: 0 = divide, 1 = modulo
- req_a  in  NREQ*WIDTH  dividends, requester i at bits [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  divisors, same packing
- req_ready  out  NREQ  one-hot grant, combinational from req_valid and priority pointer
- rsp_valid  out  NREQ  one-hot response strobe, one cycle
- rsp_data  out  WIDTH  result, valid while any rsp_valid bit is set
- rsp_dz  out  1  response was a divide/modulo by zero
- inflight  out  3  number of operations in the pipeline (0..LAT)
- dz_err  out  1  sticky divide-by-zero error (see Configuration)

## Operation
- Priority pointer `ptr` (0..NREQ-1). Winner = first i with req_valid[i] set, scanning ptr, ptr+1, … modulo NREQ.
- req_ready[winner] = 1; all other ready bits 0. No requests -> req_ready = 0.
- Handshake: transfer occurs in a cycle where req_valid[i] & req_ready[i]. Requester holds a, b and mod stable while valid is high and ready is low. It may drop valid without a transfer.
- On transfer: ptr <= (winner+1) mod NREQ, with wrap from NREQ-1 to 0. With no transfer, ptr holds.
- Stage 0 captures {id, mod, a, b, valid}. Stages 1..LAT-1 shift the entry. The result is computed combinationally at the final stage and registered into the outputs.
- Arithmetic:
  - Unsigned: quotient a/b truncates; remainder a%b.
  - SIGNED=1: quotient truncates toward zero; remainder takes the sign of the dividend (Factorio combinator semantics).
  - SIGNED=1, most-negative / -1: result is the most-negative value; mod result is 0.
  - b == 0: rsp_data = 0 and rsp_dz = 1, for both div and mod.
- inflight = count of valid stage entries.
  - Increments on transfer.
  - Decrements when a response issues.
  - Holds when both occur in the same cycle.
- No response backpressure: each requester must consume rsp_valid in the cycle it is asserted.
- Requesters may issue back-to-back. Throughput is 1 op/cycle across all requesters. A single requester with continuous valid gets every cycle only when no other requester is valid.

## Timing
- Reset values:
  - ptr = 0, all stage valids = 0.
  - rsp_valid = 0, rsp_data = 0, rsp_dz = 0.
  - inflight = 0, dz_err = 0.
  - req_ready follows the combinational rule with ptr = 0.
- Latency: transfer at edge t -> rsp_valid[id] high for exactly the cycle after edge t+LAT.
- Responses return in grant order. Only one rsp_valid bit is ever set.
- rst asserted mid-operation: all in-flight entries are discarded on that edge, and no response is issued for them. Requests presented while rst is high are not transferred (req_ready forced 0 during rst).
- Simultaneous requests from all NREQ: grants are issued in ptr order, one per cycle, with no starvation. The maximum wait is NREQ-1 cycles.

## Configuration
- V2F_DIVMOD_DZ_TRAP_EN defined:
  - dz_err sets on the response edge of any b == 0 operation.
  - dz_err stays high until rst.
  - The response is still issued with rsp_data = 0.
- Undefined: dz_err is tied to 0 and the sticky register is not built. rsp_dz is still produced.

## Test plan
- Single request: rst, then req 1 with a=100, b=7, div. Expect req_ready=0010, rsp_valid=0010 exactly LAT cycles later, rsp_data=14. Repeat with mod -> 2.
- All four valid continuously from reset: grants 0,1,2,3,0 on consecutive cycles, responses in the same order, inflight saturates at LAT.
- SIGNED=1:
  - -7/2 -> -3, -7%2 -> -1.
  - 7%-2 -> 1.
  - 0x80000000 / -1 -> 0x80000000.
- Divide by zero: a=5, b=0, mod. Expect rsp_data=0 and rsp_dz=1. With V2F_DIVMOD_DZ_TRAP_EN, dz_err goes high and stays high until rst. Without it, dz_err=0.
- Reset mid-flight: two ops granted, rst asserted on the next edge. Expect no rsp_valid, inflight=0, and ptr=0 afterwards.
- Wrap and fairness:
  - ptr=3 with requesters 3 and 0 both valid: grant 3, then 0.
  - Requester 2 drops valid before it is granted: no transfer, ptr unchanged.
